// File: rtl/botassium_s2_pkg.sv
// Shared constants for the s2 ring writer: memory map, CTRL bits, HDR layout and FSM states.
// Software header generation reads the same values, so keep them in sync with the firmware.
package botassium_s2_pkg;

  localparam int S2_ADDR_W = 7;
  localparam int S2_DATA_W = 32;

  localparam logic [S2_ADDR_W-1:0] HDR_ADDR  = 7'd0;
  localparam logic [S2_ADDR_W-1:0] CTRL_ADDR = 7'd127;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam int HDR_PTR_LSB  = 0;
  localparam int HDR_DROP_LSB = 16;
  localparam int HDR_DROP_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_HDR,
    ST_POLL_RD,
    ST_POLL_WAIT
  } s2_state_e;

  // HDR word: {drop_cnt, 9'b0, wr_ptr}
  function automatic logic [S2_DATA_W-1:0] pack_hdr(input logic [HDR_DROP_W-1:0] drop,
                                                    input logic [S2_ADDR_W-1:0]  ptr);
    logic [S2_DATA_W-1:0] w;
    w = '0;
    w[HDR_DROP_LSB +: HDR_DROP_W] = drop;
    w[HDR_PTR_LSB +: S2_ADDR_W]   = ptr;
    return w;
  endfunction

endpackage

// File: rtl/botassium_s2_ring_writer.sv
// Writes accepted samples into the shared-memory ring via port s2, keeps the HDR word current,
// and periodically polls the CTRL word for enable/clear from the Nios.
module botassium_s2_ring_writer
  import botassium_s2_pkg::*;
#(
  parameter int POLL_PERIOD = 1024,
  parameter int RING_BASE   = 1,
  parameter int RING_LAST   = 126
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 sample_valid,
  input  logic [S2_DATA_W-1:0] sample_data,
  output logic                 sample_ready,
  output logic [S2_ADDR_W-1:0] mem_address,
  output logic                 mem_chipselect,
  output logic                 mem_clken,
  output logic                 mem_write,
  output logic [S2_DATA_W-1:0] mem_writedata,
  output logic [3:0]           mem_byteenable,
  input  logic [S2_DATA_W-1:0] mem_readdata,
  output logic                 capture_en
);

  localparam int                   TIMER_W    = $clog2(POLL_PERIOD);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);
  localparam logic [S2_ADDR_W-1:0] BASE_ADDR  = S2_ADDR_W'(RING_BASE);
  localparam logic [S2_ADDR_W-1:0] LAST_ADDR  = S2_ADDR_W'(RING_LAST);

  s2_state_e              state_q, state_d;
  logic [S2_ADDR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [HDR_DROP_W-1:0]  dropCnt_q, dropCnt_d;
  logic                   enable_q, enable_d;
  logic                   prevClr_q, prevClr_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   pollPend_q, pollPend_d;
  logic                   sampleReady_q, sampleReady_d;
  logic [S2_ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic                   memCs_q, memCs_d;
  logic                   memWe_q, memWe_d;
  logic [S2_DATA_W-1:0]   memWdata_q, memWdata_d;
  logic [3:0]             memBe_q, memBe_d;
  logic                   memClken_q, memClken_d;
  logic                   unusedRdata;

  assign unusedRdata = ^mem_readdata[S2_DATA_W-1:2];

  // Bus registers are loaded on the edge that enters a state, so each strobe is visible in that state.
  always_comb begin
    state_d       = state_q;
    wrPtr_d       = wrPtr_q;
    dropCnt_d     = dropCnt_q;
    enable_d      = enable_q;
    prevClr_d     = prevClr_q;
    pollPend_d    = pollPend_q;
    memAddr_d     = memAddr_q;
    memWdata_d    = memWdata_q;
    memCs_d       = 1'b0;
    memWe_d       = 1'b0;
    memBe_d       = 4'h0;
    memClken_d    = 1'b1;

    if (timer_q == TIMER_LAST) begin
      timer_d    = '0;
      pollPend_d = 1'b1;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (pollPend_q) begin
          state_d    = ST_POLL_RD;
          pollPend_d = 1'b0;
          memCs_d    = 1'b1;
          memBe_d    = 4'hF;
          memAddr_d  = CTRL_ADDR;
        end else if (sampleReady_q && sample_valid) begin
          if (enable_q) begin
            state_d    = ST_WR_DATA;
            memCs_d    = 1'b1;
            memWe_d    = 1'b1;
            memBe_d    = 4'hF;
            memAddr_d  = wrPtr_q;
            memWdata_d = sample_data;
          end else if (dropCnt_q != '1) begin
            dropCnt_d = dropCnt_q + HDR_DROP_W'(1);
          end
        end
      end
      ST_WR_DATA: begin
        wrPtr_d    = (wrPtr_q == LAST_ADDR) ? BASE_ADDR : wrPtr_q + S2_ADDR_W'(1);
        state_d    = ST_WR_HDR;
        memCs_d    = 1'b1;
        memWe_d    = 1'b1;
        memBe_d    = 4'hF;
        memAddr_d  = HDR_ADDR;
        memWdata_d = pack_hdr(dropCnt_q, wrPtr_d);
      end
      ST_WR_HDR: state_d = ST_IDLE;
      ST_POLL_RD: state_d = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        enable_d  = mem_readdata[CTRL_EN_BIT];
        prevClr_d = mem_readdata[CTRL_CLR_BIT];
        // Clear fires only on a rising edge of the bit, so software must drop it to clear again.
        if (mem_readdata[CTRL_CLR_BIT] && !prevClr_q) begin
          wrPtr_d    = BASE_ADDR;
          dropCnt_d  = '0;
          state_d    = ST_WR_HDR;
          memCs_d    = 1'b1;
          memWe_d    = 1'b1;
          memBe_d    = 4'hF;
          memAddr_d  = HDR_ADDR;
          memWdata_d = pack_hdr('0, BASE_ADDR);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sampleReady_d = (state_d == ST_IDLE) && !pollPend_d;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q       <= ST_IDLE;
      wrPtr_q       <= BASE_ADDR;
      dropCnt_q     <= '0;
      enable_q      <= 1'b0;
      prevClr_q     <= 1'b0;
      timer_q       <= '0;
      pollPend_q    <= 1'b0;
      sampleReady_q <= 1'b0;
      memAddr_q     <= '0;
      memCs_q       <= 1'b0;
      memWe_q       <= 1'b0;
      memWdata_q    <= '0;
      memBe_q       <= 4'h0;
      memClken_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wrPtr_q       <= wrPtr_d;
      dropCnt_q     <= dropCnt_d;
      enable_q      <= enable_d;
      prevClr_q     <= prevClr_d;
      timer_q       <= timer_d;
      pollPend_q    <= pollPend_d;
      sampleReady_q <= sampleReady_d;
      memAddr_q     <= memAddr_d;
      memCs_q       <= memCs_d;
      memWe_q       <= memWe_d;
      memWdata_q    <= memWdata_d;
      memBe_q       <= memBe_d;
      memClken_q    <= memClken_d;
    end
  end

  assign sample_ready   = sampleReady_q;
  assign mem_address    = memAddr_q;
  assign mem_chipselect = memCs_q;
  assign mem_clken      = memClken_q;
  assign mem_write      = memWe_q;
  assign mem_writedata  = memWdata_q;
  assign mem_byteenable = memBe_q;
  assign capture_en     = enable_q;

endmodule

// File: tb/tb_botassium_s2_ring_writer.sv
// Directed bench for the s2 ring writer: a small memory model answers the CTRL reads and
// a negedge monitor records every bus write for the hand-computed checks below.
module tb_botassium_s2_ring_writer;

  localparam int PERIOD = 32;

  logic        clk;
  logic        reset_reset;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        sample_ready;
  logic [6:0]  mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        capture_en;

  logic [31:0] mem [0:127];
  logic [31:0] ctrlWord;

  int checkCount = 0;
  int errorCount = 0;
  int negCnt = 0;
  int ringWrites = 0;
  int lastRingNeg = 0;
  int lastHdrNeg = 0;
  int lastRdNeg = 0;
  int beViol = 0;
  int sameAddr = 0;
  logic [6:0]  lastRingAddr = '0;
  logic [31:0] lastRingData = '0;
  logic [31:0] lastHdr = '0;
  logic        prevCs = 1'b0;
  logic [6:0]  prevAddr = '0;

  botassium_s2_ring_writer #(
    .POLL_PERIOD(PERIOD),
    .RING_BASE  (1),
    .RING_LAST  (126)
  ) dut (
    .clk_clk       (clk),
    .reset_reset   (reset_reset),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .sample_ready  (sample_ready),
    .mem_address   (mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_clken     (mem_clken),
    .mem_write     (mem_write),
    .mem_writedata (mem_writedata),
    .mem_byteenable(mem_byteenable),
    .mem_readdata  (mem_readdata),
    .capture_en    (capture_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: writes land on the edge, reads return data one cycle later; CTRL comes from ctrlWord.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else mem_readdata <= (mem_address == 7'd127) ? ctrlWord : mem[mem_address];
    end
  end

  always @(negedge clk) begin
    negCnt++;
    if (mem_chipselect) begin
      if (mem_byteenable != 4'hF) beViol++;
      if (prevCs && prevAddr == mem_address) sameAddr++;
      if (mem_write) begin
        if (mem_address == 7'd0) begin
          lastHdr    = mem_writedata;
          lastHdrNeg = negCnt;
        end else begin
          ringWrites++;
          lastRingAddr = mem_address;
          lastRingData = mem_writedata;
          lastRingNeg  = negCnt;
        end
      end else begin
        lastRdNeg = negCnt;
      end
    end
    prevCs   = mem_chipselect;
    prevAddr = mem_address;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Offers one sample and returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] data);
    logic gotReady;
    gotReady     = 1'b0;
    sample_data  = data;
    sample_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (sample_ready) begin
        gotReady = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("ready_seen", {31'b0, gotReady}, 32'd1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic waitPollStrobe();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_chipselect && !mem_write) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("poll_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic waitCapture(input logic level);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (capture_en == level) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("capture_wait", {31'b0, seen}, 32'd1);
  endtask

  initial begin
    int n;
    int ringBefore;
    logic seen;
    logic inWin;

    reset_reset  = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    ctrlWord     = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'b0, sample_ready}, 32'd0);
    checkOutput("rst_capture", {31'b0, capture_en}, 32'd0);
    checkOutput("rst_cs", {31'b0, mem_chipselect}, 32'd0);
    checkOutput("rst_we", {31'b0, mem_write}, 32'd0);
    checkOutput("rst_addr", {25'b0, mem_address}, 32'd0);
    checkOutput("rst_wdata", mem_writedata, 32'd0);
    checkOutput("rst_be", {28'b0, mem_byteenable}, 32'd0);
    checkOutput("rst_clken", {31'b0, mem_clken}, 32'd0);

    // First poll returns enable only.
    ctrlWord    = 32'h1;
    reset_reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", {31'b0, sample_ready}, 32'd1);
    checkOutput("post_rst_clken", {31'b0, mem_clken}, 32'd1);
    n = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mem_chipselect && !mem_write) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    checkOutput("first_poll_seen", {31'b0, seen}, 32'd1);
    checkOutput("first_poll_addr", {25'b0, mem_address}, 32'd127);
    inWin = (n >= PERIOD) && (n <= PERIOD + 1);
    checkOutput("first_poll_cycle", {31'b0, inWin}, 32'd1);
    @(negedge clk);
    checkOutput("capture_p1", {31'b0, capture_en}, 32'd0);
    @(negedge clk);
    checkOutput("capture_p2", {31'b0, capture_en}, 32'd1);

    applyStimulus(32'hDEADBEEF);
    repeat (3) @(negedge clk);
    checkOutput("s1_ring_addr", {25'b0, lastRingAddr}, 32'd1);
    checkOutput("s1_ring_data", lastRingData, 32'hDEADBEEF);
    checkOutput("s1_hdr", lastHdr, 32'h0000_0002);
    checkOutput("s1_hdr_follows", lastHdrNeg - lastRingNeg, 32'd1);

    // Disabled: five samples are dropped while ready stays high.
    ctrlWord = 32'h0;
    waitCapture(1'b0);
    ringBefore   = ringWrites;
    sample_data  = 32'h0000_BAD0;
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("drop_ready", {31'b0, sample_ready}, 32'd1);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    checkOutput("drop_no_ring", ringWrites - ringBefore, 32'd0);
    ctrlWord = 32'h1;
    waitCapture(1'b1);
    applyStimulus(32'h1111_1111);
    repeat (3) @(negedge clk);
    checkOutput("s2_ring_addr", {25'b0, lastRingAddr}, 32'd2);
    checkOutput("s2_hdr_drop", lastHdr, 32'h0005_0003);

    // Rising clear bit resets the ring; a repeated 0x3 does not.
    ctrlWord = 32'h3;
    waitPollStrobe();
    repeat (2) @(negedge clk);
    checkOutput("clr_cs", {31'b0, mem_chipselect}, 32'd1);
    checkOutput("clr_we", {31'b0, mem_write}, 32'd1);
    checkOutput("clr_addr", {25'b0, mem_address}, 32'd0);
    checkOutput("clr_hdr", mem_writedata, 32'h0000_0001);
    waitPollStrobe();
    repeat (2) @(negedge clk);
    checkOutput("no_reclear", {31'b0, mem_chipselect}, 32'd0);

    // Ring wrap: 127 samples from a cleared pointer.
    ringBefore = ringWrites;
    for (int i = 0; i < 127; i++) applyStimulus(32'hA000_0000 + i);
    repeat (3) @(negedge clk);
    checkOutput("wrap_count", ringWrites - ringBefore, 32'd127);
    checkOutput("wrap_last_addr", {25'b0, lastRingAddr}, 32'd1);
    checkOutput("wrap_hdr", lastHdr, 32'h0000_0002);
    checkOutput("wrap_mem1", mem[1], 32'hA000_007E);
    checkOutput("wrap_mem2", mem[2], 32'hA000_0001);
    checkOutput("wrap_mem126", mem[126], 32'hA000_007D);

    // Sample waiting while the poll timer expires: poll goes first, sample follows.
    waitPollStrobe();
    repeat (PERIOD - 1) @(negedge clk);
    checkOutput("pend_blocks_ready", {31'b0, sample_ready}, 32'd0);
    applyStimulus(32'h5A5A_5A5A);
    repeat (3) @(negedge clk);
    checkOutput("coll_order", lastRingNeg - lastRdNeg, 32'd3);
    checkOutput("coll_data", lastRingData, 32'h5A5A_5A5A);
    checkOutput("coll_addr", {25'b0, lastRingAddr}, 32'd2);
    checkOutput("coll_hdr", lastHdr, 32'h0000_0003);

    // Reset during WR_DATA aborts the HDR write.
    ctrlWord = 32'h1;
    applyStimulus(32'h7777_7777);
    reset_reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort_cs", {31'b0, mem_chipselect}, 32'd0);
    checkOutput("abort_we", {31'b0, mem_write}, 32'd0);
    checkOutput("abort_addr", {25'b0, mem_address}, 32'd0);
    checkOutput("abort_wdata", mem_writedata, 32'd0);
    checkOutput("abort_ready", {31'b0, sample_ready}, 32'd0);
    checkOutput("abort_capture", {31'b0, capture_en}, 32'd0);
    checkOutput("abort_hdr_mem", mem[0], 32'h0000_0003);
    checkOutput("abort_ring_mem", mem[3], 32'h7777_7777);
    @(negedge clk);
    reset_reset = 1'b0;
    waitCapture(1'b1);
    applyStimulus(32'h1234_5678);
    repeat (3) @(negedge clk);
    checkOutput("after_rst_addr", {25'b0, lastRingAddr}, 32'd1);
    checkOutput("after_rst_hdr", lastHdr, 32'h0000_0002);

    checkOutput("byteenable_rule", beViol, 32'd0);
    checkOutput("no_b2b_same_addr", sameAddr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/botassium_s2_ring_writer.md
# botassium_s2_ring_writer

Sample producer for the Nios shared on-chip memory. Accepts 32-bit samples from FPGA-side sensor logic and writes them into a ring buffer through the memory's second port (s2), updating a header word after every sample. It also periodically reads a control word that the Nios writes, so software can enable capture and clear the ring. Sits directly upstream of the `nios_mem_s2_*` slave of the system top.

## Interface
Parameters:
- `POLL_PERIOD`, default 1024: cycles between control-word reads, 2..65535.
- `RING_BASE`, default 1: first ring word address.
- `RING_LAST`, default 126: last ring word address. Must be greater than `RING_BASE`.

Ports:
- `clk_clk`  in  1  the single clock.
- `reset_reset`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  a sample is offered.
- `sample_data`  in  32  sample word.
- `sample_ready`  out  1  block accepts the sample this cycle.
- `mem_address`  out  7  word address; connects to `nios_mem_s2_address`.
- `mem_chipselect`  out  1  access strobe.
- `mem_clken`  out  1  memory clock enable.
- `mem_write`  out  1  1 = write, 0 = read.
- `mem_writedata`  out  32  write data.
- `mem_byteenable`  out  4  byte lanes; always 4'hF when `mem_chipselect`=1.
- `mem_readdata`  in  32  read data, valid one cycle after a read strobe.
- `capture_en`  out  1  current enable bit, for status LEDs.

## Operation
Memory map:
- Word 0 is HDR. Layout: {drop_cnt[15:0], 9'b0, wr_ptr[6:0]}.
- Words `RING_BASE`..`RING_LAST` are the ring.
- Word 127 is CTRL. Bit0 = enable, bit1 = clear.

FSM states:
- **IDLE**
  - If `poll_pend`=1: go to POLL_RD, `sample_ready`=0.
  - Else `sample_ready`=1. On `sample_valid`:
    - enable=1: latch the sample, go to WR_DATA.
    - enable=0: drop the sample, `drop_cnt`++ (saturating at 16'hFFFF), stay in IDLE.
- **WR_DATA**: write the latched sample at `wr_ptr`. Then advance `wr_ptr`: if `wr_ptr`==`RING_LAST` it becomes `RING_BASE`, else it increments. Go to WR_HDR.
- **WR_HDR**: write HDR using the updated `wr_ptr` and `drop_cnt`. Go to IDLE.
- **POLL_RD**: read strobe to address 127. Go to POLL_WAIT.
- **POLL_WAIT**: capture `mem_readdata`.
  - enable ← bit0.
  - On a 0→1 change of bit1 versus the previous captured value: `wr_ptr` ← `RING_BASE`, `drop_cnt` ← 0, go to WR_HDR.
  - Otherwise go to IDLE.

Poll timer:
- Free-running counter. On reaching `POLL_PERIOD`-1 it sets `poll_pend` and wraps to 0.
- `poll_pend` clears on entry to POLL_RD.
- A timer expiry while `poll_pend` is already set is absorbed; there is no double poll.

Other rules:
- Clear acts only on the rising edge of bit1. Software must drop bit1 before it can clear again.
- `capture_en` equals the enable register.

## Timing
- Reset values (one edge after `reset_reset`=1):
  - state = IDLE
  - `wr_ptr` = `RING_BASE`, `drop_cnt` = 0, enable = 0, previous clear = 0
  - poll timer = 0, `poll_pend` = 0
  - `sample_ready` = 0 (goes to 1 in the first cycle after reset), `capture_en` = 0
  - `mem_chipselect` = 0, `mem_write` = 0, `mem_address` = 0, `mem_writedata` = 0, `mem_byteenable` = 0, `mem_clken` = 0
- Out of reset, `mem_clken` is held at 1.
- `mem_*` outputs are registered and asserted for exactly one cycle per access. There are no back-to-back accesses to the same address.
- Reset mid-operation aborts any pending write on the same edge. Memory contents are left untouched.
- Sample path: accept at edge N. RING write strobe is on the bus in cycle N+1, HDR write in N+2, `sample_ready` is 1 again in N+3. Maximum throughput is one sample per 3 cycles.
- Poll path: read strobe in cycle P, `mem_readdata` sampled at the end of P+1. A clear-triggered HDR write happens in P+2.
- Simultaneous events:
  - `poll_pend` and `sample_valid` both present in IDLE: poll wins and the sample waits (`sample_ready`=0).
  - A poll request arriving during WR_DATA/WR_HDR is deferred to the next IDLE.
- `sample_data` is sampled only on an accepting edge. The held copy is stable through WR_DATA.

## Structure
- Package `botassium_s2_pkg`, shared with software header generation:
  - `S2_ADDR_W`=7, `S2_DATA_W`=32
  - `HDR_ADDR`=0, `CTRL_ADDR`=127
  - `CTRL_EN_BIT`=0, `CTRL_CLR_BIT`=1
  - HDR field offsets
  - FSM state enum
- Single module, no sub-module. The poll timer is an inline counter of width $clog2(`POLL_PERIOD`).

## Test plan
- After reset, read strobe at cycle `POLL_PERIOD` with CTRL=0x1 returned → `capture_en`=1 two cycles later. Then send sample 0xDEADBEEF → RING write addr 1 data 0xDEADBEEF, then HDR write 0x0000_0002.
- Enable=0, five samples → no RING writes, `sample_ready` held 1. Next HDR written after enabling shows `drop_cnt`=5 (0x0005_xxxx).
- 127 consecutive samples → addresses 1..126 written, 127th lands on addr 1, and the final HDR has `wr_ptr`=2.
- CTRL returns 0x3 after prior 0x1 → HDR write 0x0000_0001 in POLL_WAIT+1. Next poll with 0x3 again → no clear.
- `sample_valid` held high while the poll timer expires in IDLE → POLL_RD first, sample accepted at POLL_WAIT+1, no sample lost.
- Assert `reset_reset` during WR_DATA → no write strobe next cycle, all outputs at reset values, `wr_ptr`=1.
